ysyx_23060240_mem_arb: RTL and testbench
========================================

# ysyx_23060240_mem_arb

Two-requester memory arbiter and sequencer between the IFU (instruction fetch, read-only) and the LSU (load/store) in front of the single shared data-memory port. The downstream port is the DPI-backed pmem access used by the MEM stage. The block accepts one request at a time through valid/ready handshakes and drives the shared port. It routes each response back to the requester that owns it, and returns an error response if memory does not reply within a bounded time.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- TIMEOUT, 255, maximum WAIT cycles before an error response; legal range 1..255 (8-bit counter)

Ports:
- clk  in  1  single clock; all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- ifu_req_valid  in  1  IFU read request
- ifu_req_ready  out  1  IFU request accepted this cycle
- ifu_req_addr  in  ADDR_W  fetch address
- ifu_resp_valid  out  1  one-cycle response pulse to IFU
- ifu_resp_data  out  DATA_W  fetched word
- ifu_resp_err  out  1  timeout error
- lsu_req_valid  in  1  LSU request
- lsu_req_ready  out  1  LSU request accepted this cycle
- lsu_req_wen  in  1  1 = write, 0 = read
- lsu_req_addr  in  ADDR_W  address
- lsu_req_wdata  in  DATA_W  write data
- lsu_req_wmask  in  8  byte write mask (same encoding as the pmem_write mask)
- lsu_resp_valid  out  1  one-cycle response pulse to LSU; also acknowledges writes
- lsu_resp_rdata  out  DATA_W  read data; 0 for writes
- lsu_resp_err  out  1  timeout error
- mem_req_valid  out  1  request to the shared port
- mem_req_ready  in  1  port accepts the request
- mem_req_wen, mem_req_addr, mem_req_wdata, mem_req_wmask  out  1/ADDR_W/DATA_W/8  registered request fields
- mem_resp_valid  in  1  port response
- mem_resp_rdata  in  DATA_W  port read data

## Operation
- **FSM states:** IDLE, ISSUE, WAIT. Reset state is IDLE.
- **IDLE, arbitration:**
  - Exactly one requester is offered ready.
  - If only one requester is valid, that requester gets ready.
  - If both are valid, round-robin picks the one not served last.
  - The last-owner register resets to LSU, so IFU wins the first tie.
  - If neither is valid, both ready outputs are 0.
  - ready is combinational from the valid inputs and the last-owner register; it is never asserted outside IDLE.
- **IDLE, capture:** on handshake (valid & ready) the request fields and owner are captured into registers, last-owner is updated, and the FSM goes to ISSUE.
  - IFU requests are captured with wen = 0, wdata = 0, wmask = 0.
- **ISSUE:**
  - mem_req_valid = 1 with the registered fields, held stable until mem_req_ready.
  - On mem_req_ready: go to WAIT and clear the timeout counter.
- **WAIT:**
  - The counter increments every cycle.
  - On mem_resp_valid: load the owner's response registers with err = 0 and go to IDLE.
    - Read data = mem_resp_rdata for reads; rdata = 0 for LSU writes.
  - If the counter reaches TIMEOUT without mem_resp_valid: respond with err = 1 and data = 0, then go to IDLE.
- **Response outputs:** *_resp_valid is a registered pulse, high for exactly one cycle, and only for the owner. Data and err outputs hold their last values until the next response.
- **Unsolicited responses:** mem_resp_valid in IDLE or ISSUE is ignored, including late responses after a timeout.
- There is never more than one outstanding transaction.

## Timing
- **Reset:** all outputs are 0 and all internal registers are cleared. A reset asserted mid-transaction abandons it with no response pulse.
- **Latency:**
  - Handshake in cycle N.
  - mem_req_valid from N+1.
  - If mem_req_ready = 1 at N+1, WAIT starts at N+2.
  - mem_resp_valid in cycle M gives owner resp_valid in cycle M+1.
  - Minimum request-to-response is 3 cycles for a same-cycle memory response in the first WAIT cycle.
- **Back-to-back:** the cycle that shows resp_valid is an IDLE cycle, so a new handshake can occur in that same cycle.
- **Timeout:** err pulse in cycle W0+TIMEOUT+1, where W0 is the first WAIT cycle.
- **Simultaneous mem_resp_valid and counter == TIMEOUT:** the real response wins and err = 0.
- **Requester withdraws valid before ready:** no capture; arbitration is re-evaluated the next cycle.

## Structure
- Package **ysyx_23060240_mem_pkg**:
  - state enum {IDLE, ISSUE, WAIT}
  - owner enum {OWN_IFU, OWN_LSU}
  - ADDR_W/DATA_W defaults
  - WMASK_W = 8
- Sub-module **ysyx_23060240_rr_arb2**: 2-way round-robin picker.
  - Inputs: two valids, last owner, enable.
  - Output: one-hot grant.
  - Purely combinational.
- The FSM, counter and capture/response registers live in the top module.

## Test plan
- **Single IFU read:** ifu_req addr 0x80000000; mem_req_ready = 1 immediately; mem_resp_rdata 0x00000413 on the first WAIT cycle -> ifu_resp_valid one cycle with data 0x00000413, err 0, total latency 3; lsu_resp_valid stays 0.
- **Simultaneous requests after reset:** IFU and LSU valid together -> IFU granted first, LSU second. Repeat the tie -> IFU next; grants alternate.
- **LSU write:** addr 0x80001000, wdata 0xDEADBEEF, wmask 0x0F; mem_req_ready delayed 3 cycles -> mem_req fields stable throughout; lsu_resp_valid with rdata 0, err 0.
- **Timeout:** TIMEOUT = 4, no mem_resp_valid -> lsu_resp_err = 1 and rdata 0 in cycle W0+5; a later stray mem_resp_valid is ignored with no pulse.
- **Response at the timeout boundary:** mem_resp_valid exactly at counter == TIMEOUT -> err 0 with real data.
- **Reset mid-WAIT:** drop rst_n during WAIT -> all outputs 0 immediately; no response pulse after release; next request is served normally.

Source files
------------

// File: rtl/ysyx_23060240_mem_pkg.sv
// ysyx_23060240 memory arbiter: shared types
// and default widths for the IFU/LSU arbiter.
package ysyx_23060240_mem_pkg;

    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DATA_W = 32;
    localparam int WMASK_W    = 8;
    localparam int CNT_W      = 8;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT
    } state_t;

    typedef enum logic {
        OWN_IFU,
        OWN_LSU
    } owner_t;

endpackage

// File: rtl/ysyx_23060240_rr_arb2.sv
// ysyx_23060240 two-way round-robin picker.
// Purely combinational one-hot grant: bit 0 = IFU, bit 1 = LSU.
module ysyx_23060240_rr_arb2
    import ysyx_23060240_mem_pkg::*;
(
    input  logic       en,
    input  logic       ifu_valid,
    input  logic       lsu_valid,
    input  owner_t     last,
    output logic [1:0] grant
);

    logic tie;

    always_comb begin
        tie   = ifu_valid & lsu_valid;
        grant = 2'b00;
        if (en) begin
            // On a tie the requester not served last wins.
            grant[0] = ifu_valid & (~tie | (last == OWN_LSU));
            grant[1] = lsu_valid & (~tie | (last == OWN_IFU));
        end
    end

endmodule

// File: rtl/ysyx_23060240_mem_arb.sv
// ysyx_23060240 IFU/LSU arbiter and sequencer in front of
// the shared pmem port, with a bounded wait for responses.
module ysyx_23060240_mem_arb
    import ysyx_23060240_mem_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int TIMEOUT = 255
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ifu_req_valid,
    output logic               ifu_req_ready,
    input  logic [ADDR_W-1:0]  ifu_req_addr,
    output logic               ifu_resp_valid,
    output logic [DATA_W-1:0]  ifu_resp_data,
    output logic               ifu_resp_err,
    input  logic               lsu_req_valid,
    output logic               lsu_req_ready,
    input  logic               lsu_req_wen,
    input  logic [ADDR_W-1:0]  lsu_req_addr,
    input  logic [DATA_W-1:0]  lsu_req_wdata,
    input  logic [WMASK_W-1:0] lsu_req_wmask,
    output logic               lsu_resp_valid,
    output logic [DATA_W-1:0]  lsu_resp_rdata,
    output logic               lsu_resp_err,
    output logic               mem_req_valid,
    input  logic               mem_req_ready,
    output logic               mem_req_wen,
    output logic [ADDR_W-1:0]  mem_req_addr,
    output logic [DATA_W-1:0]  mem_req_wdata,
    output logic [WMASK_W-1:0] mem_req_wmask,
    input  logic               mem_resp_valid,
    input  logic [DATA_W-1:0]  mem_resp_rdata
);

    localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT);

    state_t           state, state_nxt;
    owner_t           owner, last;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       grant;
    logic             hs_ifu, hs_lsu;
    logic             resp_hit, tmo_hit, done;

    ysyx_23060240_rr_arb2 u_arb (
        .en        ((state == IDLE) & rst_n),
        .ifu_valid (ifu_req_valid),
        .lsu_valid (lsu_req_valid),
        .last      (last),
        .grant     (grant)
    );

    assign ifu_req_ready = grant[0];
    assign lsu_req_ready = grant[1];
    assign hs_ifu        = ifu_req_valid & grant[0];
    assign hs_lsu        = lsu_req_valid & grant[1];
    assign mem_req_valid = (state == ISSUE);

    // A real response beats a timeout landing in the same cycle.
    assign resp_hit = (state == WAIT) & mem_resp_valid;
    assign tmo_hit  = (state == WAIT) & ~mem_resp_valid & (cnt == TMO);
    assign done     = resp_hit | tmo_hit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (hs_ifu | hs_lsu) state_nxt = ISSUE;
            ISSUE:   if (mem_req_ready) state_nxt = WAIT;
            WAIT:    if (done) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner         <= OWN_IFU;
            last          <= OWN_LSU;
            mem_req_wen   <= 1'b0;
            mem_req_addr  <= '0;
            mem_req_wdata <= '0;
            mem_req_wmask <= '0;
        end else if (hs_ifu) begin
            owner         <= OWN_IFU;
            last          <= OWN_IFU;
            mem_req_wen   <= 1'b0;
            mem_req_addr  <= ifu_req_addr;
            mem_req_wdata <= '0;
            mem_req_wmask <= '0;
        end else if (hs_lsu) begin
            owner         <= OWN_LSU;
            last          <= OWN_LSU;
            mem_req_wen   <= lsu_req_wen;
            mem_req_addr  <= lsu_req_addr;
            mem_req_wdata <= lsu_req_wdata;
            mem_req_wmask <= lsu_req_wmask;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (state == ISSUE && mem_req_ready) begin
            cnt <= '0;
        end else if (state == WAIT) begin
            cnt <= cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ifu_resp_valid <= 1'b0;
            ifu_resp_data  <= '0;
            ifu_resp_err   <= 1'b0;
            lsu_resp_valid <= 1'b0;
            lsu_resp_rdata <= '0;
            lsu_resp_err   <= 1'b0;
        end else begin
            ifu_resp_valid <= done & (owner == OWN_IFU);
            lsu_resp_valid <= done & (owner == OWN_LSU);
            if (done && owner == OWN_IFU) begin
                ifu_resp_data <= resp_hit ? mem_resp_rdata : '0;
                ifu_resp_err  <= tmo_hit;
            end
            if (done && owner == OWN_LSU) begin
                lsu_resp_rdata <= (resp_hit && !mem_req_wen)
                                  ? mem_resp_rdata : '0;
                lsu_resp_err   <= tmo_hit;
            end
        end
    end

endmodule

// File: tb/tb_ysyx_23060240_mem_arb.sv
// ysyx_23060240 memory arbiter bench: vector table, hand-written
// corner sequences and randomized transactions vs a timing model.
module tb_ysyx_23060240_mem_arb;

    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ifu_req_valid, ifu_req_ready;
    logic [31:0] ifu_req_addr;
    logic        ifu_resp_valid;
    logic [31:0] ifu_resp_data;
    logic        ifu_resp_err;
    logic        lsu_req_valid, lsu_req_ready, lsu_req_wen;
    logic [31:0] lsu_req_addr, lsu_req_wdata;
    logic [7:0]  lsu_req_wmask;
    logic        lsu_resp_valid;
    logic [31:0] lsu_resp_rdata;
    logic        lsu_resp_err;
    logic        mem_req_valid, mem_req_ready, mem_req_wen;
    logic [31:0] mem_req_addr, mem_req_wdata;
    logic [7:0]  mem_req_wmask;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_rdata;

    int checks = 0;
    int errors = 0;
    logic m_last;  // 0 = IFU served last, 1 = LSU served last

    always #5 clk = ~clk;

    ysyx_23060240_mem_arb #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst_n(rst_n),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready),
        .ifu_req_addr(ifu_req_addr), .ifu_resp_valid(ifu_resp_valid),
        .ifu_resp_data(ifu_resp_data), .ifu_resp_err(ifu_resp_err),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready),
        .lsu_req_wen(lsu_req_wen), .lsu_req_addr(lsu_req_addr),
        .lsu_req_wdata(lsu_req_wdata), .lsu_req_wmask(lsu_req_wmask),
        .lsu_resp_valid(lsu_resp_valid), .lsu_resp_rdata(lsu_resp_rdata),
        .lsu_resp_err(lsu_resp_err),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_wen(mem_req_wen), .mem_req_addr(mem_req_addr),
        .mem_req_wdata(mem_req_wdata), .mem_req_wmask(mem_req_wmask),
        .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(mem_resp_rdata)
    );

    typedef struct {
        logic        iv, lv, we;
        logic [31:0] ia, la, wd;
        logic [7:0]  wm;
        logic [31:0] rd;
        int          rdly, dly;
        logic        ei, el;
    } vec_t;

    vec_t tbl[9];

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic any_out();
        return |{ifu_req_ready, ifu_resp_valid, ifu_resp_data,
                 ifu_resp_err, lsu_req_ready, lsu_resp_valid,
                 lsu_resp_rdata, lsu_resp_err, mem_req_valid,
                 mem_req_wen, mem_req_addr, mem_req_wdata,
                 mem_req_wmask};
    endfunction

    // One full transaction; timing expectations come from the
    // request/ready/response delays, data from the request kind.
    task automatic run_txn(input logic iv, lv, we,
                           input logic [31:0] ia, la, wd,
                           input logic [7:0] wm,
                           input logic [31:0] rd,
                           input int rdly, dly,
                           input logic ei, el);
        logic        own_i, tmo;
        int          wlen;
        logic [31:0] ed, eaddr, ewd;
        logic [7:0]  ewm;
        logic        ewe;
        tick();
        ifu_req_valid = iv; ifu_req_addr = ia;
        lsu_req_valid = lv; lsu_req_wen = we; lsu_req_addr = la;
        lsu_req_wdata = wd; lsu_req_wmask = wm;
        mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
        #4;
        chk("ifu_ready", ifu_req_ready, ei);
        chk("lsu_ready", lsu_req_ready, el);
        if (!(ei | el)) begin
            ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;
            return;
        end
        own_i  = ei;
        m_last = el;
        ewe   = own_i ? 1'b0 : we;
        eaddr = own_i ? ia : la;
        ewd   = own_i ? 32'h0 : wd;
        ewm   = own_i ? 8'h0 : wm;
        for (int k = 0; k <= rdly; k++) begin
            tick();
            ifu_req_valid = 1'($urandom); lsu_req_valid = 1'($urandom);
            ifu_req_addr = $urandom; lsu_req_addr = $urandom;
            lsu_req_wdata = $urandom; lsu_req_wen = 1'($urandom);
            mem_req_ready = (k == rdly);
            mem_resp_valid = 1'($urandom);
            mem_resp_rdata = $urandom;
            #4;
            chk("issue_valid", mem_req_valid, 1'b1);
            chk("issue_wen", mem_req_wen, ewe);
            chk("issue_addr", mem_req_addr, eaddr);
            chk("issue_wdata", mem_req_wdata, ewd);
            chk("issue_wmask", mem_req_wmask, ewm);
            chk("issue_rdy", {ifu_req_ready, lsu_req_ready}, 2'b00);
            chk("issue_resp", {ifu_resp_valid, lsu_resp_valid}, 2'b00);
        end
        tmo  = (dly > TMO);
        wlen = tmo ? TMO : dly;
        for (int k = 0; k <= wlen; k++) begin
            tick();
            ifu_req_valid = 1'($urandom); lsu_req_valid = 1'($urandom);
            mem_req_ready = 1'b0;
            mem_resp_valid = !tmo && (k == dly);
            mem_resp_rdata = (k == dly) ? rd : $urandom;
            #4;
            chk("wait_valid", mem_req_valid, 1'b0);
            chk("wait_rdy", {ifu_req_ready, lsu_req_ready}, 2'b00);
            chk("wait_resp", {ifu_resp_valid, lsu_resp_valid}, 2'b00);
        end
        ed = (tmo || (!own_i && we)) ? 32'h0 : rd;
        tick();
        ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;
        mem_resp_valid = 1'b1; mem_resp_rdata = 32'hBAD0_BAD0;
        #4;
        chk("resp_ifu_v", ifu_resp_valid, own_i);
        chk("resp_lsu_v", lsu_resp_valid, !own_i);
        if (own_i) begin
            chk("resp_ifu_d", ifu_resp_data, ed);
            chk("resp_ifu_e", ifu_resp_err, tmo);
        end else begin
            chk("resp_lsu_d", lsu_resp_rdata, ed);
            chk("resp_lsu_e", lsu_resp_err, tmo);
        end
        tick();
        #4;
        chk("pulse_end", {ifu_resp_valid, lsu_resp_valid}, 2'b00);
        chk("hold_data", own_i ? ifu_resp_data : lsu_resp_rdata, ed);
        mem_resp_valid = 1'b0;
    endtask

    initial begin
        logic iv, lv, ei, el;
        rst_n = 1'b0;
        ifu_req_valid = 0; ifu_req_addr = 0;
        lsu_req_valid = 0; lsu_req_wen = 0; lsu_req_addr = 0;
        lsu_req_wdata = 0; lsu_req_wmask = 0;
        mem_req_ready = 0; mem_resp_valid = 0; mem_resp_rdata = 0;
        m_last = 1'b1;

        tbl[0] = '{1, 0, 0, 32'h8000_0000, 0, 0, 0,
                   32'h0000_0413, 0, 0, 1, 0};
        tbl[1] = '{1, 1, 1, 32'h8000_0004, 32'h8000_1000,
                   32'hDEAD_BEEF, 8'h0F, 32'h1111_1111, 3, 1, 0, 1};
        tbl[2] = '{1, 1, 0, 32'h8000_0008, 32'h8000_2000, 0, 0,
                   32'h2222_3333, 0, TMO, 1, 0};
        tbl[3] = '{1, 1, 0, 32'h8000_000C, 32'h8000_3000, 0, 0,
                   32'h4444_5555, 1, 9, 0, 1};
        tbl[4] = '{0, 1, 0, 0, 32'h8000_4000, 0, 0,
                   32'h6666_7777, 2, 2, 0, 1};
        tbl[5] = '{0, 1, 1, 0, 32'h8000_5000, 32'h0102_0304, 8'hF0,
                   32'h8888_9999, 0, 0, 0, 1};
        tbl[6] = '{1, 1, 0, 32'h8000_0010, 32'h8000_6000, 0, 0,
                   32'hAAAA_BBBB, 1, 3, 1, 0};
        tbl[7] = '{0, 0, 0, 32'h8000_0014, 32'h8000_7000, 0, 0,
                   32'h0, 0, 0, 0, 0};
        tbl[8] = '{1, 0, 0, 32'h8000_0018, 0, 0, 0,
                   32'hCCCC_DDDD, 0, 5, 1, 0};

        #12;
        chk("reset_outs", any_out(), 1'b0);
        tick();
        rst_n = 1'b1;

        foreach (tbl[i])
            run_txn(tbl[i].iv, tbl[i].lv, tbl[i].we, tbl[i].ia,
                    tbl[i].la, tbl[i].wd, tbl[i].wm, tbl[i].rd,
                    tbl[i].rdly, tbl[i].dly, tbl[i].ei, tbl[i].el);

        // New handshake in the same cycle that shows a response.
        tick();
        ifu_req_valid = 1; ifu_req_addr = 32'h8000_0100; #4;
        chk("b2b_ifu_rdy", ifu_req_ready, 1'b1);
        tick();
        ifu_req_valid = 0; mem_req_ready = 1; #4;
        tick();
        mem_req_ready = 0; mem_resp_valid = 1;
        mem_resp_rdata = 32'h1234_5678; #4;
        tick();
        mem_resp_valid = 0; lsu_req_valid = 1; lsu_req_wen = 0;
        lsu_req_addr = 32'h8000_0200; #4;
        chk("b2b_ifu_resp", ifu_resp_valid, 1'b1);
        chk("b2b_ifu_data", ifu_resp_data, 32'h1234_5678);
        chk("b2b_lsu_rdy", lsu_req_ready, 1'b1);
        tick();
        lsu_req_valid = 0; mem_req_ready = 1; #4;
        chk("b2b_issue", mem_req_valid, 1'b1);
        chk("b2b_addr", mem_req_addr, 32'h8000_0200);
        tick();
        mem_req_ready = 0; mem_resp_valid = 1;
        mem_resp_rdata = 32'hCAFE_F00D; #4;
        tick();
        mem_resp_valid = 0; #4;
        chk("b2b_lsu_resp", lsu_resp_valid, 1'b1);
        chk("b2b_lsu_data", lsu_resp_rdata, 32'hCAFE_F00D);
        m_last = 1'b1;

        // Reset dropped in the middle of WAIT.
        tick();
        lsu_req_valid = 1; lsu_req_wen = 1; lsu_req_addr = 32'h8000_0300;
        lsu_req_wdata = 32'h5555_AAAA; lsu_req_wmask = 8'hFF; #4;
        chk("rst_lsu_rdy", lsu_req_ready, 1'b1);
        tick();
        lsu_req_valid = 0; mem_req_ready = 1; #4;
        tick();
        mem_req_ready = 0; #4;
        tick();
        rst_n = 1'b0; #1;
        chk("midrst_outs", any_out(), 1'b0);
        tick();
        mem_resp_valid = 1; rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            #4;
            chk("midrst_nopulse", {ifu_resp_valid, lsu_resp_valid}, 2'b00);
            chk("midrst_idle", mem_req_valid, 1'b0);
        end
        mem_resp_valid = 0;
        m_last = 1'b1;
        run_txn(1, 1, 0, 32'h8000_0400, 32'h8000_0500, 0, 0,
                32'h7777_0000, 0, 1, 1, 0);

        // Randomized transactions; winner is whoever was not served last.
        for (int n = 0; n < 150; n++) begin
            iv = 1'($urandom);
            lv = 1'($urandom);
            ei = iv && (!lv || m_last);
            el = lv && (!iv || !m_last);
            run_txn(iv, lv, 1'($urandom), $urandom, $urandom, $urandom,
                    8'($urandom), $urandom, $urandom_range(0, 3),
                    $urandom_range(0, 7), ei, el);
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
